// File: rtl/vec_mem_access_unit.sv
// vec_mem_access_unit
// MEM-stage sequencer that runs scalar and V-lane vector loads/stores over a
// single-word synchronous memory port, one word per cycle, stalling the
// pipeline while a transfer is in flight. Load results are collected in a
// V-word buffer that feeds the MEM/WB register.

module vec_mem_access_unit #(
    parameter int N = 32,
    parameter int V = 20
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           req_i,
    input  logic           MemRead_i,
    input  logic           MemWrite_i,
    input  logic           VecOp_i,
    input  logic [N-1:0]   Addr_i,
    input  logic [N-1:0]   Data_Store_S_i,
    input  logic [V*N-1:0] Data_Store_V_i,
    output logic [N-1:0]   mem_addr_o,
    output logic [N-1:0]   mem_wdata_o,
    output logic           mem_we_o,
    output logic           mem_re_o,
    input  logic [N-1:0]   mem_rdata_i,
    output logic           stall_o,
    output logic [N-1:0]   Data_Mem_S_o,
    output logic [V*N-1:0] Data_Mem_V_o
);

    localparam int IW = $clog2(V + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [IW-1:0] idx;
    logic [IW-1:0] cnt;
    logic [IW-1:0] rd_idx;
    logic          rd_valid;
    logic          is_store;
    logic [N-1:0]  addr_q;
    logic [N-1:0]  store_data [V];
    logic [N-1:0]  load_buf   [V];

    logic          start;
    logic          last;

    // A write wins over a simultaneous read, so any request with either
    // strobe set starts a transfer.
    assign start = req_i && (MemRead_i || MemWrite_i);
    assign last  = (idx == (cnt - IW'(1)));

    // State register; reset drops any transfer in progress for good.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and memory-port outputs; the port is only driven in ISSUE.
    // The request-cycle stall is gated by RST so every output reads 0 while
    // reset is held.
    always_comb begin
        state_next  = state;
        stall_o     = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = 1'b0;
        mem_re_o    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ISSUE;
                    stall_o    = RST;
                end
            end
            ISSUE: begin
                stall_o    = 1'b1;
                mem_addr_o = addr_q + N'(idx);
                if (is_store) begin
                    mem_we_o    = 1'b1;
                    mem_wdata_o = store_data[idx];
                end else begin
                    mem_re_o = 1'b1;
                end
                if (last) begin
                    state_next = is_store ? DONE : WAIT;
                end
            end
            WAIT: begin
                stall_o    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latching, word index and load capture; read data returns one
    // cycle after the strobe, so the lane being filled trails idx by one.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            idx      <= '0;
            cnt      <= IW'(1);
            rd_idx   <= '0;
            rd_valid <= 1'b0;
            is_store <= 1'b0;
            addr_q   <= '0;
            for (int i = 0; i < V; i++) begin
                store_data[i] <= '0;
                load_buf[i]   <= '0;
            end
        end else begin
            rd_valid <= mem_re_o;
            rd_idx   <= idx;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_store <= MemWrite_i;
                        cnt      <= VecOp_i ? IW'(V) : IW'(1);
                        addr_q   <= Addr_i;
                        idx      <= '0;
                        for (int i = 0; i < V; i++) begin
                            if (VecOp_i) begin
                                store_data[i] <= Data_Store_V_i[i*N +: N];
                            end else if (i == 0) begin
                                store_data[i] <= Data_Store_S_i;
                            end else begin
                                store_data[i] <= '0;
                            end
                            if (!MemWrite_i) begin
                                load_buf[i] <= '0;
                            end
                        end
                    end
                end
                ISSUE: begin
                    idx <= idx + IW'(1);
                end
                default: begin
                end
            endcase
            if (rd_valid) begin
                load_buf[rd_idx] <= mem_rdata_i;
            end
        end
    end

    assign Data_Mem_S_o = load_buf[0];

    for (genvar g = 0; g < V; g++) begin : g_lane
        assign Data_Mem_V_o[g*N +: N] = load_buf[g];
    end

endmodule

// File: tb/tb_vec_mem_access_unit.sv
// Testbench for vec_mem_access_unit: a behavioural memory plus a transfer-level
// reference model (word list, latency, expected load buffer) drive
// directed and randomized scenarios.

module tb_vec_mem_access_unit;

    localparam int N = 32;
    localparam int V = 20;

    logic           clk;
    logic           rst_n;
    logic           req;
    logic           mem_read;
    logic           mem_write;
    logic           vec_op;
    logic [N-1:0]   addr;
    logic [N-1:0]   sd;
    logic [V*N-1:0] vd;
    logic [N-1:0]   mem_addr;
    logic [N-1:0]   mem_wdata;
    logic           mem_we;
    logic           mem_re;
    logic [N-1:0]   mem_rdata;
    logic           stall;
    logic [N-1:0]   dm_s;
    logic [V*N-1:0] dm_v;

    int vectors = 0;
    int miscompares = 0;

    logic [N-1:0]   mem_a [logic [N-1:0]];
    logic [N-1:0]   wr_addr_q [$];
    logic [N-1:0]   wr_data_q [$];
    int             rd_cnt = 0;
    logic           pend_rd = 1'b0;
    logic [N-1:0]   pend_addr = '0;
    logic [V*N-1:0] model_buf = '0;

    vec_mem_access_unit #(.N(N), .V(V)) dut (
        .CLK            (clk),
        .RST            (rst_n),
        .req_i          (req),
        .MemRead_i      (mem_read),
        .MemWrite_i     (mem_write),
        .VecOp_i        (vec_op),
        .Addr_i         (addr),
        .Data_Store_S_i (sd),
        .Data_Store_V_i (vd),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_we_o       (mem_we),
        .mem_re_o       (mem_re),
        .mem_rdata_i    (mem_rdata),
        .stall_o        (stall),
        .Data_Mem_S_o   (dm_s),
        .Data_Mem_V_o   (dm_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] mem_rd(input logic [N-1:0] a);
        if (mem_a.exists(a)) return mem_a[a];
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory model: strobes sampled mid-cycle, read data returned on the next edge
    always @(negedge clk) begin
        #2;
        pend_rd   = mem_re;
        pend_addr = mem_addr;
        if (mem_re) rd_cnt++;
        if (mem_we) begin
            mem_a[mem_addr] = mem_wdata;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    always @(posedge clk) begin
        mem_rdata <= pend_rd ? mem_rd(pend_addr) : N'($urandom);
    end

    task automatic run_op(input bit rd, input bit wr, input bit vec,
                          input logic [N-1:0] base, input logic [N-1:0] sdata,
                          input logic [V*N-1:0] vdata);
        int cnt, lat, wr0, rd0;
        bit st, ld, exp_stall, exp_we, exp_re;
        logic [N-1:0] exp_addr, exp_wd;
        logic [V*N-1:0] prev_buf, exp_b;
        st  = wr;
        ld  = rd && !wr;
        cnt = vec ? V : 1;
        lat = ld ? cnt + 2 : cnt + 1;
        prev_buf = model_buf;
        if (ld) begin
            model_buf = '0;
            for (int i = 0; i < cnt; i++) model_buf[i*N +: N] = mem_rd(base + 32'(i));
        end
        wr0 = wr_addr_q.size();
        rd0 = rd_cnt;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            req = 1'b1;
            if (k == 0) begin
                mem_read = rd; mem_write = wr; vec_op = vec;
                addr = base; sd = sdata; vd = vdata;
            end else begin
                mem_read = 1'($urandom); mem_write = 1'($urandom); vec_op = 1'($urandom);
                addr = N'($urandom); sd = N'($urandom); vd = {V{N'($urandom)}};
            end
            #1;
            exp_stall = (k < lat);
            exp_we = st && k >= 1 && k <= cnt;
            exp_re = ld && k >= 1 && k <= cnt;
            vectors++;
            if (stall !== exp_stall) begin
                miscompares++;
                $display("[TB] FAIL stall cyc%0d: got %b expected %b", k, stall, exp_stall);
            end
            vectors++;
            if (mem_we !== exp_we) begin
                miscompares++;
                $display("[TB] FAIL we cyc%0d: got %b expected %b", k, mem_we, exp_we);
            end
            vectors++;
            if (mem_re !== exp_re) begin
                miscompares++;
                $display("[TB] FAIL re cyc%0d: got %b expected %b", k, mem_re, exp_re);
            end
            if (exp_we || exp_re) begin
                exp_addr = base + 32'(k - 1);
                vectors++;
                if (mem_addr !== exp_addr) begin
                    miscompares++;
                    $display("[TB] FAIL addr cyc%0d: got %h expected %h", k, mem_addr, exp_addr);
                end
                if (exp_we) begin
                    exp_wd = vec ? vdata[(k-1)*N +: N] : sdata;
                    vectors++;
                    if (mem_wdata !== exp_wd) begin
                        miscompares++;
                        $display("[TB] FAIL wdata cyc%0d: got %h expected %h", k, mem_wdata, exp_wd);
                    end
                end
            end
            if (k == 0 || k == lat) begin
                exp_b = (k == 0) ? prev_buf : model_buf;
                vectors++;
                if (dm_v !== exp_b) begin
                    miscompares++;
                    $display("[TB] FAIL data_v cyc%0d: got %h expected %h", k, dm_v, exp_b);
                end
                vectors++;
                if (dm_s !== exp_b[N-1:0]) begin
                    miscompares++;
                    $display("[TB] FAIL data_s cyc%0d: got %h expected %h", k, dm_s, exp_b[N-1:0]);
                end
            end
        end
        @(negedge clk);
        req = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        #1;
        vectors++;
        if (stall !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL post_done_idle: got stall/we/re %b%b%b expected 000", stall, mem_we, mem_re);
        end
        #2;
        if (st) begin
            vectors++;
            if (wr_addr_q.size() - wr0 != cnt) begin
                miscompares++;
                $display("[TB] FAIL write_count: got %0d expected %0d", wr_addr_q.size() - wr0, cnt);
            end else begin
                for (int i = 0; i < cnt; i++) begin
                    exp_addr = base + 32'(i);
                    exp_wd   = vec ? vdata[i*N +: N] : sdata;
                    vectors++;
                    if (wr_addr_q[wr0+i] !== exp_addr || wr_data_q[wr0+i] !== exp_wd) begin
                        miscompares++;
                        $display("[TB] FAIL write_log%0d: got %h@%h expected %h@%h", i,
                                 wr_data_q[wr0+i], wr_addr_q[wr0+i], exp_wd, exp_addr);
                    end
                end
            end
        end
        vectors++;
        if (rd_cnt - rd0 != (ld ? cnt : 0)) begin
            miscompares++;
            $display("[TB] FAIL read_count: got %0d expected %0d", rd_cnt - rd0, ld ? cnt : 0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 1'b1; mem_read = 1'b1; mem_write = 1'b0; vec_op = 1'b1;
        addr = 32'h10; sd = '0; vd = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if ({stall, mem_we, mem_re} !== 3'b000 || mem_addr !== '0 || mem_wdata !== '0
                || dm_s !== '0 || dm_v !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs: got stall/we/re %b%b%b addr %h expected all 0",
                         stall, mem_we, mem_re, mem_addr);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            vectors++;
            if ({stall, mem_we, mem_re} !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL nonmem_req: got stall/we/re %b%b%b expected 000", stall, mem_we, mem_re);
            end
        end
        model_buf = '0;
    endtask

    task automatic test_scalar_load();
        mem_a[32'h100] = 32'hDEADBEEF;
        run_op(1'b1, 1'b0, 1'b0, 32'h100, '0, '0);
    endtask

    task automatic test_vector_store();
        logic [V*N-1:0] v;
        for (int i = 0; i < V; i++) v[i*N +: N] = 32'(i + 1);
        run_op(1'b0, 1'b1, 1'b1, 32'h200, '0, v);
    endtask

    task automatic test_vector_load_wrap();
        run_op(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, '0, '0);
    endtask

    task automatic test_read_write_conflict();
        run_op(1'b1, 1'b1, 1'b0, 32'h40, 32'h55, '0);
    endtask

    task automatic test_reset_mid_transfer();
        int wr0;
        @(negedge clk);
        wr0 = wr_addr_q.size();
        req = 1'b1; mem_read = 1'b0; mem_write = 1'b1; vec_op = 1'b1;
        addr = 32'h300; vd = {V{32'hCAFE_0001}};
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            req = 1'b0;
            #1;
            vectors++;
            if (mem_we !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL midreset_we cyc%0d: got %b expected 1", k, mem_we);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({stall, mem_we, mem_re} !== 3'b000 || mem_addr !== '0 || dm_v !== '0) begin
            miscompares++;
            $display("[TB] FAIL midreset_drop: got stall/we/re %b%b%b addr %h expected 0",
                     stall, mem_we, mem_re, mem_addr);
        end
        model_buf = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if ({stall, mem_we, mem_re} !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL midreset_idle cyc%0d: got stall/we/re %b%b%b expected 000",
                         c, stall, mem_we, mem_re);
            end
        end
        #2;
        vectors++;
        if (wr_addr_q.size() - wr0 != 7) begin
            miscompares++;
            $display("[TB] FAIL midreset_writes: got %0d expected 7", wr_addr_q.size() - wr0);
        end
    endtask

    task automatic test_random();
        bit rd, wr, vec;
        logic [N-1:0] base;
        logic [V*N-1:0] v;
        for (int t = 0; t < 16; t++) begin
            rd  = 1'($urandom);
            wr  = 1'($urandom);
            vec = 1'($urandom);
            base = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + N'($urandom_range(0, 15)))
                                               : N'($urandom);
            for (int i = 0; i < V; i++) v[i*N +: N] = N'($urandom);
            if (!rd && !wr) begin
                @(negedge clk);
                req = 1'b1; mem_read = 1'b0; mem_write = 1'b0; vec_op = vec; addr = base;
                #1;
                vectors++;
                if ({stall, mem_we, mem_re} !== 3'b000 || dm_v !== model_buf) begin
                    miscompares++;
                    $display("[TB] FAIL rand_nonmem%0d: got stall/we/re %b%b%b expected 000, buffer held",
                             t, stall, mem_we, mem_re);
                end
                @(negedge clk);
                req = 1'b0;
            end else begin
                run_op(rd, wr, vec, base, N'($urandom), v);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req = 1'b0; mem_read = 1'b0; mem_write = 1'b0; vec_op = 1'b0;
        addr = '0; sd = '0; vd = '0;
        test_reset();
        test_scalar_load();
        test_vector_store();
        test_vector_load_wrap();
        test_read_write_conflict();
        test_reset_mid_transfer();
        test_scalar_load();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
